// File: rtl/addsub_ctrl16.sv
// Request/response sequencer around an external 16-bit adder with Z/N/C/V flags.
// Define ADDSUB_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYCLES edges.
module addsub_ctrl16 #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_op,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   output logic        add_en,
   output logic        add_c_in,
   output logic [15:0] add_a,
   output logic [15:0] add_b,
   input  logic [15:0] add_sum,
   input  logic        add_c_out,
   input  logic        add_ready,
   output logic        res_valid,
   input  logic        res_ack,
   output logic [15:0] res_data,
   output logic [3:0]  res_flags,
   output logic        res_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state;

   logic z, n, v, same_sign;

   // Subtract is A + ~B + 1, so overflow needs the raw operand signs to differ.
   always_comb begin
      z = (add_sum == 16'h0000);
      n = add_sum[15];
      same_sign = (add_a[15] == add_b[15]);
      v = (add_c_in ? !same_sign : same_sign) & (add_sum[15] != add_a[15]);
   end

`ifdef ADDSUB_TIMEOUT_EN
   localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT_CYCLES - 1);
   logic [3:0] cnt;
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign res_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         add_en    <= 1'b0;
         add_c_in  <= 1'b0;
         add_a     <= 16'h0000;
         add_b     <= 16'h0000;
         res_valid <= 1'b0;
         res_data  <= 16'h0000;
         res_flags <= 4'h0;
`ifdef ADDSUB_TIMEOUT_EN
         res_err   <= 1'b0;
         cnt       <= 4'h0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  add_a     <= req_a;
                  add_b     <= req_b;
                  add_c_in  <= req_op;
                  add_en    <= 1'b1;
                  req_ready <= 1'b0;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
`ifdef ADDSUB_TIMEOUT_EN
               cnt   <= 4'h0;
`endif
               state <= WAIT;
            end
            WAIT: begin
               if (add_ready) begin
                  res_data  <= add_sum;
                  res_flags <= {z, n, add_c_out, v};
`ifdef ADDSUB_TIMEOUT_EN
                  res_err   <= 1'b0;
`endif
                  res_valid <= 1'b1;
                  add_en    <= 1'b0;
                  state     <= DONE;
               end
`ifdef ADDSUB_TIMEOUT_EN
               else if (cnt == LAST_WAIT) begin
                  res_data  <= 16'h0000;
                  res_flags <= 4'h0;
                  res_err   <= 1'b1;
                  res_valid <= 1'b1;
                  add_en    <= 1'b0;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + 4'h1;
               end
`endif
            end
            DONE: begin
               if (res_ack) begin
                  res_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_ctrl16.sv
// Directed bench for addsub_ctrl16; adder responses are hand-computed constants.
// Timeout checks follow ADDSUB_TIMEOUT_EN when it is defined.
module tb_addsub_ctrl16;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_op;
   logic [15:0] req_a, req_b;
   logic        add_en, add_c_in;
   logic [15:0] add_a, add_b, add_sum;
   logic        add_c_out, add_ready;
   logic        res_valid, res_ack;
   logic [15:0] res_data;
   logic [3:0]  res_flags;
   logic        res_err;

   int n_tests = 0;
   int n_fail  = 0;

   addsub_ctrl16 #(.TIMEOUT_CYCLES(15)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .add_en(add_en), .add_c_in(add_c_in), .add_a(add_a), .add_b(add_b),
      .add_sum(add_sum), .add_c_out(add_c_out), .add_ready(add_ready),
      .res_valid(res_valid), .res_ack(res_ack),
      .res_data(res_data), .res_flags(res_flags), .res_err(res_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 0; req_op = 0; req_a = 0; req_b = 0;
      add_sum = 0; add_c_out = 0; add_ready = 0; res_ack = 0;
      #2;
      chk("rst_req_ready", 16'(req_ready), 16'd1);
      chk("rst_add_en", 16'(add_en), 16'd0);
      chk("rst_res_valid", 16'(res_valid), 16'd0);
      chk("rst_res_data", res_data, 16'h0000);
      chk("rst_res_flags", 16'(res_flags), 16'h0);
      chk("rst_res_err", 16'(res_err), 16'd0);
      chk("rst_add_a", add_a, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      // stray ack in IDLE is ignored
      res_ack = 1;
      tick();
      chk("idle_ack_valid", 16'(res_valid), 16'd0);
      chk("idle_ack_ready", 16'(req_ready), 16'd1);
      res_ack = 0;

      // add 0x1234 + 0x0001
      req_valid = 1; req_a = 16'h1234; req_b = 16'h0001; req_op = 0;
      tick();
      req_valid = 0;
      chk("add_accept_ready", 16'(req_ready), 16'd0);
      chk("add_issue_en", 16'(add_en), 16'd1);
      chk("add_issue_a", add_a, 16'h1234);
      chk("add_issue_b", add_b, 16'h0001);
      chk("add_issue_cin", 16'(add_c_in), 16'd0);
      tick();
      chk("add_wait_valid", 16'(res_valid), 16'd0);
      chk("add_wait_en", 16'(add_en), 16'd1);
      add_ready = 1; add_sum = 16'h1235; add_c_out = 0;
      tick();
      add_ready = 0;
      chk("add_done_valid", 16'(res_valid), 16'd1);
      chk("add_done_data", res_data, 16'h1235);
      chk("add_done_flags", 16'(res_flags), 16'h0);
      chk("add_done_en", 16'(add_en), 16'd0);
      res_ack = 1;
      tick();
      res_ack = 0;
      chk("add_ack_valid", 16'(res_valid), 16'd0);
      chk("add_ack_ready", 16'(req_ready), 16'd1);
      chk("add_ack_keep", res_data, 16'h1235);

      // subtract 0x8000 - 0x0001 overflows
      req_valid = 1; req_a = 16'h8000; req_b = 16'h0001; req_op = 1;
      tick();
      req_valid = 0;
      chk("sub_cin", 16'(add_c_in), 16'd1);
      tick();
      add_ready = 1; add_sum = 16'h7FFF; add_c_out = 1;
      tick();
      add_ready = 0;
      chk("sub_data", res_data, 16'h7FFF);
      chk("sub_flags", 16'(res_flags), 16'(4'b0011));
      res_ack = 1;
      tick();
      res_ack = 0;

      // 0xFFFF + 1 wraps to zero, then hold without ack
      req_valid = 1; req_a = 16'hFFFF; req_b = 16'h0001; req_op = 0;
      tick();
      req_valid = 0;
      tick();
      add_ready = 1; add_sum = 16'h0000; add_c_out = 1;
      tick();
      add_ready = 0;
      chk("zero_data", res_data, 16'h0000);
      chk("zero_flags", 16'(res_flags), 16'(4'b1010));
      req_valid = 1; req_a = 16'h7FFF; req_b = 16'h0001; req_op = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_valid", 16'(res_valid), 16'd1);
         chk("hold_flags", 16'(res_flags), 16'(4'b1010));
         chk("hold_ready", 16'(req_ready), 16'd0);
      end
      chk("hold_add_a", add_a, 16'hFFFF);

      // ack edge returns to IDLE; stale adder ready already asserted
      res_ack = 1; add_ready = 1; add_sum = 16'h8000; add_c_out = 0;
      tick();
      res_ack = 0;
      chk("b2b_idle_ready", 16'(req_ready), 16'd1);
      chk("b2b_idle_en", 16'(add_en), 16'd0);
      tick();
      chk("b2b_accept_a", add_a, 16'h7FFF);
      chk("b2b_accept_en", 16'(add_en), 16'd1);
      req_valid = 0; req_b = 16'h5555;
      tick();
      chk("stale_issue_valid", 16'(res_valid), 16'd0);
      chk("stale_b_held", add_b, 16'h0001);
      tick();
      add_ready = 0;
      chk("stale_done_valid", 16'(res_valid), 16'd1);
      chk("stale_data", res_data, 16'h8000);
      chk("stale_flags", 16'(res_flags), 16'(4'b0101));
      res_ack = 1;
      tick();
      res_ack = 0;

      // reset pulsed in WAIT
      req_valid = 1; req_a = 16'h0100; req_b = 16'h0200; req_op = 1;
      tick();
      req_valid = 0;
      tick();
      chk("rstw_en_before", 16'(add_en), 16'd1);
      #2 rst = 1;
      #1;
      chk("rstw_ready", 16'(req_ready), 16'd1);
      chk("rstw_en", 16'(add_en), 16'd0);
      chk("rstw_a", add_a, 16'h0000);
      chk("rstw_b", add_b, 16'h0000);
      chk("rstw_cin", 16'(add_c_in), 16'd0);
      chk("rstw_valid", 16'(res_valid), 16'd0);
      chk("rstw_data", res_data, 16'h0000);
      #1 rst = 0;
      req_valid = 1; req_a = 16'h0003; req_b = 16'h0005; req_op = 1;
      tick();
      req_valid = 0;
      chk("post_rst_accept", 16'(add_en), 16'd1);
      chk("post_rst_cin", 16'(add_c_in), 16'd1);
      tick();
      add_ready = 1; add_sum = 16'hFFFE; add_c_out = 0;
      tick();
      add_ready = 0;
      chk("post_rst_valid", 16'(res_valid), 16'd1);
      chk("post_rst_data", res_data, 16'hFFFE);
      chk("post_rst_flags", 16'(res_flags), 16'(4'b0100));
      res_ack = 1;
      tick();
      res_ack = 0;

      // adder never answers
      req_valid = 1; req_a = 16'h1111; req_b = 16'h2222; req_op = 0;
      tick();
      req_valid = 0;
      tick();
      for (int i = 1; i < 15; i++) begin
         tick();
         chk("to_wait_valid", 16'(res_valid), 16'd0);
      end
      tick();
`ifdef ADDSUB_TIMEOUT_EN
      chk("to_valid", 16'(res_valid), 16'd1);
      chk("to_err", 16'(res_err), 16'd1);
      chk("to_data", res_data, 16'h0000);
      chk("to_flags", 16'(res_flags), 16'h0);
      res_ack = 1;
      tick();
      res_ack = 0;
      req_valid = 1;
      tick();
      req_valid = 0;
      tick();
      for (int i = 1; i < 15; i++) tick();
      chk("race_wait_valid", 16'(res_valid), 16'd0);
`else
      chk("nto_wait_valid", 16'(res_valid), 16'd0);
      for (int i = 0; i < 10; i++) tick();
      chk("nto_long_valid", 16'(res_valid), 16'd0);
`endif
      add_ready = 1; add_sum = 16'h3333; add_c_out = 0;
      tick();
      add_ready = 0;
      chk("race_valid", 16'(res_valid), 16'd1);
      chk("race_err", 16'(res_err), 16'd0);
      chk("race_data", res_data, 16'h3333);
      res_ack = 1;
      tick();
      res_ack = 0;
      chk("end_ready", 16'(req_ready), 16'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
